// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register chain: DEPTH valid/ready stages carrying a WIDTH-bit payload.
// Empty stages keep accepting while the output stalls, and flush squashes everything in flight.
module pipe_reg_elastic #(
  parameter int unsigned      WIDTH     = 64,
  parameter int unsigned      DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] adv;

  // A stage may advance when downstream drains or any stage from it to the output is empty.
  // Written as a reduction over the tail rather than a bit-to-bit chain on one vector.
  for (genvar g = 0; g < DEPTH; g++) begin : g_adv
    assign adv[g] = out_ready | ~(&v_q[DEPTH-1:g]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
    end else if (flush) begin
      v_q <= '0;
    end else begin
      // Data loads regardless of incoming valid, keeping invalid stages deterministic.
      if (adv[0]) begin
        data_q[0] <= in_data;
        v_q[0]    <= in_valid;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i]) begin
          data_q[i] <= data_q[i-1];
          v_q[i]    <= v_q[i-1];
        end
      end
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CW'(v_q[i]);
    end
  end

  assign in_ready  = adv[0] & ~flush;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Directed vector bench for pipe_reg_elastic: a DEPTH=3 instance and a DEPTH=1 instance,
// each driven from a table of per-cycle inputs with the outputs expected before the edge.
module tb_pipe_reg_elastic;

  typedef struct {
    logic       rst;
    logic       fl;
    logic       iv;
    logic [7:0] d;
    logic       orr;
    logic       chk;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [1:0] e_cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset0 = 1'b1, iv0 = 1'b0, or0 = 1'b0, fl0 = 1'b0;
  logic [7:0] d0 = 8'h00;
  logic       ir0, ov0;
  logic [7:0] od0;
  logic [1:0] cnt0;

  logic       reset1 = 1'b1, iv1 = 1'b0, or1 = 1'b0, fl1 = 1'b0;
  logic [7:0] d1 = 8'h00;
  logic       ir1, ov1;
  logic [7:0] od1;
  logic [0:0] cnt1;

  pipe_reg_elastic #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) dut0 (
    .clk(clk), .reset(reset0), .in_data(d0), .in_valid(iv0), .in_ready(ir0),
    .out_data(od0), .out_valid(ov0), .out_ready(or0), .flush(fl0), .count(cnt0)
  );

  pipe_reg_elastic #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'hA5)) dut1 (
    .clk(clk), .reset(reset1), .in_data(d1), .in_valid(iv1), .in_ready(ir1),
    .out_data(od1), .out_valid(ov1), .out_ready(or1), .flush(fl1), .count(cnt1)
  );

  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(logic rst, logic fl, logic iv, logic [7:0] d, logic orr,
                              logic chk, logic e_ir, logic e_ov, logic [7:0] e_od,
                              logic [1:0] e_cnt);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.orr = orr;
    v.chk = chk; v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(string nm, int idx, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  vec_t t0[$];
  vec_t t1[$];
  int   lat;

  initial begin
    // DEPTH=3: reset, stream, stall, bubble collapse, flush
    t0.push_back(mk(1,0,0,8'h00,0, 0,0,0,8'h00,0));
    t0.push_back(mk(0,0,0,8'h00,0, 1,1,0,8'h00,0));
    t0.push_back(mk(0,0,1,8'h11,1, 1,1,0,8'h00,0));
    t0.push_back(mk(0,0,1,8'h22,1, 1,1,0,8'h00,1));
    t0.push_back(mk(0,0,1,8'h33,1, 1,1,0,8'h00,2));
    t0.push_back(mk(0,0,1,8'h44,1, 1,1,1,8'h11,3));
    t0.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'h22,3));
    t0.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'h33,2));
    t0.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'h44,1));
    t0.push_back(mk(0,0,0,8'h00,0, 1,1,0,8'h00,0));
    t0.push_back(mk(0,0,1,8'hA1,0, 1,1,0,8'h00,0));
    t0.push_back(mk(0,0,1,8'hA2,0, 1,1,0,8'h00,1));
    t0.push_back(mk(0,0,1,8'hA3,0, 1,1,0,8'h00,2));
    t0.push_back(mk(0,0,1,8'hA4,0, 1,0,1,8'hA1,3));
    t0.push_back(mk(0,0,1,8'hA4,0, 1,0,1,8'hA1,3));
    t0.push_back(mk(0,0,1,8'hA4,1, 1,1,1,8'hA1,3));
    t0.push_back(mk(0,0,1,8'hA5,1, 1,1,1,8'hA2,3));
    t0.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'hA3,3));
    t0.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'hA4,2));
    t0.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'hA5,1));
    t0.push_back(mk(0,0,0,8'h00,0, 1,1,0,8'h00,0));
    t0.push_back(mk(0,0,1,8'hA1,0, 1,1,0,8'h00,0));
    t0.push_back(mk(0,0,0,8'h00,0, 1,1,0,8'h00,1));
    t0.push_back(mk(0,0,1,8'hA2,0, 1,1,0,8'h00,1));
    t0.push_back(mk(0,0,0,8'h00,0, 1,1,1,8'hA1,2));
    t0.push_back(mk(0,0,0,8'h00,0, 1,1,1,8'hA1,2));
    t0.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'hA1,2));
    t0.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'hA2,1));
    t0.push_back(mk(0,0,1,8'hB1,0, 1,1,0,8'h00,0));
    t0.push_back(mk(0,0,1,8'hB2,0, 1,1,0,8'h00,1));
    t0.push_back(mk(0,0,1,8'hB3,0, 1,1,0,8'h00,2));
    t0.push_back(mk(0,1,1,8'hC1,1, 1,0,1,8'hB1,3));
    t0.push_back(mk(0,0,1,8'hC1,1, 1,1,0,8'hB1,0));
    t0.push_back(mk(0,0,0,8'h00,1, 1,1,0,8'hB2,1));
    t0.push_back(mk(0,0,0,8'h00,1, 1,1,0,8'hB3,1));
    t0.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'hC1,1));
    t0.push_back(mk(0,0,0,8'h00,1, 1,1,0,8'h00,0));

    // DEPTH=1: reset value, full-rate stream, mid-stream reset, flush
    t1.push_back(mk(1,0,0,8'h00,0, 0,0,0,8'h00,0));
    t1.push_back(mk(0,0,0,8'h00,0, 1,1,0,8'hA5,0));
    t1.push_back(mk(0,0,1,8'h01,1, 1,1,0,8'h00,0));
    for (int k = 2; k <= 8; k++)
      t1.push_back(mk(0,0,1,8'(k),1, 1,1,1,8'(k-1),1));
    t1.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'h08,1));
    t1.push_back(mk(0,0,1,8'h11,1, 1,1,0,8'h00,0));
    t1.push_back(mk(0,0,1,8'h22,0, 1,0,1,8'h11,1));
    t1.push_back(mk(1,0,1,8'h33,1, 0,0,0,8'h00,0));
    t1.push_back(mk(0,0,0,8'h00,1, 1,1,0,8'hA5,0));
    t1.push_back(mk(0,0,0,8'h00,1, 1,1,0,8'h00,0));
    t1.push_back(mk(0,0,1,8'h55,0, 1,1,0,8'h00,0));
    t1.push_back(mk(0,1,1,8'h66,0, 1,0,1,8'h55,1));
    t1.push_back(mk(0,0,0,8'h00,0, 1,1,0,8'h55,0));

    foreach (t0[i]) begin
      @(negedge clk);
      reset0 = t0[i].rst; fl0 = t0[i].fl; iv0 = t0[i].iv; d0 = t0[i].d; or0 = t0[i].orr;
      #1;
      if (t0[i].chk) begin
        check("d3_in_ready",  i, {7'b0, ir0}, {7'b0, t0[i].e_ir});
        check("d3_out_valid", i, {7'b0, ov0}, {7'b0, t0[i].e_ov});
        check("d3_out_data",  i, od0, t0[i].e_od);
        check("d3_count",     i, {6'b0, cnt0}, {6'b0, t0[i].e_cnt});
      end
    end

    // Latency on an empty DEPTH=3 chain: visible two edges after the accepting edge.
    @(negedge clk);
    reset0 = 1'b0; fl0 = 1'b0; iv0 = 1'b1; d0 = 8'h5C; or0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv0 = 1'b0; d0 = 8'h00;
    lat = 0;
    while (!ov0 && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("d3_latency",      0, 8'(lat), 8'd2);
    check("d3_latency_data", 0, od0, 8'h5C);

    foreach (t1[i]) begin
      @(negedge clk);
      reset1 = t1[i].rst; fl1 = t1[i].fl; iv1 = t1[i].iv; d1 = t1[i].d; or1 = t1[i].orr;
      #1;
      if (t1[i].chk) begin
        check("d1_in_ready",  i, {7'b0, ir1}, {7'b0, t1[i].e_ir});
        check("d1_out_valid", i, {7'b0, ov1}, {7'b0, t1[i].e_ov});
        check("d1_out_data",  i, od1, t1[i].e_od);
        check("d1_count",     i, {7'b0, cnt1}, {6'b0, t1[i].e_cnt});
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_reg_elastic.md
Name: pipe_reg_elastic

Overview:
Parametrised pipeline register chain carrying a WIDTH-bit payload through DEPTH stages. Each stage has a valid bit and a valid/ready handshake on both ends. Bubbles collapse: an empty stage accepts data even while the output is stalled. Flush squashes all in-flight data. Used between CPU pipeline stages wherever stall and flush are needed.

Parameters:
WIDTH, 64, payload width in bits (>=1)
DEPTH, 1, number of register stages (>=1)
RESET_VAL, 0, value loaded into every stage data register on reset (WIDTH bits)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
in_data  input  WIDTH  payload from the upstream stage
in_valid  input  1  upstream has a payload
in_ready  output  1  chain accepts in_data this cycle
out_data  output  WIDTH  payload of the last stage, driven from stage DEPTH-1 register
out_valid  output  1  last stage holds a valid payload
out_ready  input  1  downstream accepts the payload this cycle
flush  input  1  squash all in-flight payloads
count  output  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- State: data[0..DEPTH-1] (WIDTH bits each) and v[0..DEPTH-1]. Stage 0 is the input side. Stage DEPTH-1 drives out_data and out_valid directly; there is no combinational data path from input to output.
- Reset is synchronous and active-high, and takes priority over everything. On the edge where reset=1: all v=0 and all data=RESET_VAL. After reset: out_valid=0, out_data=RESET_VAL, count=0, and in_ready=1 whenever flush=0.
- Advance condition, combinational:
  - adv[DEPTH-1] = !v[DEPTH-1] | out_ready
  - adv[i] = !v[i] | adv[i+1]
- in_ready = adv[0] & !flush.
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- Per edge, when reset=0 and flush=0, for each stage i with adv[i]=1:
  - i>0: data[i] <= data[i-1], v[i] <= v[i-1]
  - i=0: data[0] <= in_data, v[0] <= in_valid
- A stage with adv[i]=0 holds its data and valid.
- Data registers load even when the incoming valid is 0. Their contents are don't-care while the stage is invalid, but must be deterministic.
- Flush (reset=0): on the edge, all v <= 0 and data registers hold.
  - in_ready=0 during flush, so no input transfer occurs.
  - An output transfer in the flush cycle still counts; downstream owns that payload.
- count = popcount(v), registered-state derived, so it updates on the edge.
- Latency: with the chain empty, a payload accepted at edge t is visible on out_data/out_valid after edge t+DEPTH-1, i.e. DEPTH-1 edges after acceptance. For DEPTH=1 it is visible right after the accepting edge.
- Throughput: 1 payload per cycle while out_ready=1, including DEPTH=1. No cycle is lost on an out_ready 0->1 transition.
- Full: all v=1 and out_ready=0 gives in_ready=0. out_data and out_valid stay stable while out_valid=1 and out_ready=0.
- Simultaneous output and input transfer while full: the payload shifts and the chain accepts the new one, so count is unchanged.
- in_data is never sampled while in_ready=0.
- Reset asserted mid-stream: all payloads are discarded on that edge. Nothing is output afterwards until new inputs arrive.

Test Plan:
- WIDTH=8, DEPTH=3, RESET_VAL=8'h00: hold reset 1 cycle -> out_valid=0, out_data=00, count=0, in_ready=1.
- Stream 8'h11, 8'h22, 8'h33, 8'h44 back-to-back with out_ready=1:
  - 11 appears 2 edges after acceptance.
  - Then one payload per cycle, in order 11,22,33,44.
  - count peaks at 3.
- out_ready=0 with 5 payloads A1..A5 offered:
  - A1..A3 accepted; in_ready=0 afterwards; count=3; out_data=A1 stable.
  - Then out_ready=1 -> A1,A2,A3 each leave in consecutive cycles while A4 and A5 are accepted.
- Bubble collapse: load A1; insert one idle cycle (in_valid=0); load A2; hold out_ready=0 -> A1 and A2 end up in stages 2 and 1 and count=2, with in_ready still 1.
- Flush with 3 valid payloads (B1 at output) and out_ready=1 in the flush cycle:
  - B1 is transferred; in_valid=1 with C1 is not accepted (in_ready=0).
  - Next cycle: count=0, out_valid=0.
  - C1 is accepted the following cycle.
- DEPTH=1, RESET_VAL=8'hA5:
  - After reset, out_data=A5.
  - Continuous stream 01..08 with out_ready=1 -> 8 outputs in 8 consecutive cycles.
  - Reset asserted mid-stream -> out_valid=0, out_data=A5 on the next cycle.
